pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Parametrised program counter for the next CPU generation. It replaces the fixed 8-bit counter.
- Adds configurable address width, relative branches, and a hardware call/return stack with overflow and underflow detection.
- Sits between the control unit and the address bus. It drives the bus through the existing `transmitter` tri-state buffer under `i_noe`.
- Also exports an always-valid internal copy of the PC for the instruction fetcher.

Parameters:
- ADDR_W, 8, width of the program counter, data input, offset and stack entries (≥2).
- STACK_DEPTH, 4, number of return-address entries (≥1).
- CNT_W, $clog2(STACK_DEPTH+1), width of the stack-occupancy counter (derived; not to be overridden).

Ports:
- i_clk  in  1  system clock; all state updates on its rising edge.
- i_nreset  in  1  asynchronous, active-low reset.
- i_data  in  ADDR_W  absolute target for load and call.
- i_offset  in  ADDR_W  two's-complement relative branch offset.
- i_loadData  in  1  absolute jump: PC ← i_data.
- i_branch  in  1  relative jump: PC ← PC + i_offset.
- i_incr  in  1  PC ← PC + 1.
- i_call  in  1  push PC+1, then PC ← i_data.
- i_ret  in  1  pop top of stack into PC.
- i_clrErr  in  1  clears the sticky error flags.
- i_noe  in  1  active-low output enable for o_addr.
- o_addr  out  ADDR_W  PC on the bus via `transmitter`; high-Z when i_noe=1.
- o_pc  out  ADDR_W  PC, always driven.
- o_depth  out  CNT_W  current number of stack entries.
- o_empty  out  1  o_depth == 0.
- o_full  out  1  o_depth == STACK_DEPTH.
- o_overflow  out  1  sticky: call attempted while full.
- o_underflow  out  1  sticky: return attempted while empty.

Behaviour:
- Reset (i_nreset=0, asynchronous, no clock needed):
  - PC=0, depth=0, o_overflow=0, o_underflow=0.
  - Stack contents are don't-care.
  - Outputs take these values immediately: o_pc=0, o_depth=0, o_empty=1, o_full=0.
  - Reset wins over every other input.
  - Reset asserted mid-operation discards any pending update; the first edge after deassertion acts normally.
- Command priority, one action per cycle: i_ret > i_call > i_loadData > i_branch > i_incr. Lower-priority commands in the same cycle are ignored.
- No command asserted: PC and stack hold.
- Latency: the new PC is visible on o_pc/o_addr one cycle after the command edge. o_pc, o_depth and the flags are registered or derived directly from registers, with no combinational path from command inputs.
- Arithmetic:
  - All PC arithmetic is modulo 2^ADDR_W.
  - Increment wraps (2^ADDR_W−1) to 0.
  - Branch adds i_offset as two's complement, e.g. ADDR_W=8: PC=0x05, offset=0xFE gives 0x03.
  - Call pushes (PC+1) mod 2^ADDR_W.
- Stack is LIFO, indexed by depth:
  - Call when not full: stack[depth] ← PC+1; depth ← depth+1; PC ← i_data.
  - Call when full: no push, PC unchanged, depth unchanged, o_overflow ← 1.
  - Return when not empty: PC ← stack[depth−1]; depth ← depth−1.
  - Return when empty: PC unchanged, o_underflow ← 1.
- Flags:
  - o_overflow and o_underflow are sticky until i_clrErr or reset.
  - If i_clrErr coincides with a new error event, the flag ends up 1 (set wins).
  - i_clrErr does not block the command executed in the same cycle.
- o_addr is the PC when i_noe=0, high-Z otherwise. i_noe has no effect on state.
- Out-of-range parameters (ADDR_W<2, STACK_DEPTH<1) are rejected by an elaboration-time assertion.

Test Plan:
- Reset and increment: pulse i_nreset low with no clock edge → o_pc=0, o_empty=1 immediately. Then 3 cycles of i_incr → o_pc=3. With ADDR_W=8 from PC=0xFF, one incr → o_pc=0x00.
- Load and branch: i_loadData with i_data=0x40 → 0x40. Then i_branch with i_offset=0x10 → 0x50. Then i_branch with i_offset=0xF0 → 0x40. Assert i_loadData+i_branch+i_incr together with i_data=0x20 → 0x20 (load wins).
- Nested call/return, STACK_DEPTH=4:
  - At PC=0x10, call 0x80 → PC=0x80, depth=1. At PC=0x80, call 0xA0 → PC=0xA0, depth=2.
  - Return → PC=0x81, depth=1. Return → PC=0x11, depth=0, o_empty=1.
- Overflow: 4 calls → o_full=1. A 5th call to 0xC0 → PC unchanged, depth=4, o_overflow=1. 4 returns restore the pushed addresses in reverse order. o_overflow stays 1 until i_clrErr.
- Underflow and flag race: return with depth=0 → PC unchanged, o_underflow=1. i_clrErr together with another empty return → o_underflow stays 1. i_clrErr alone → 0.
- Bus and reset: i_noe=1 → o_addr=Z while o_pc is valid. At depth=2, assert i_nreset mid-cycle during an i_call → depth=0, PC=0, flags=0, with no push on the next edge.

Source files
------------

// File: rtl/pc_stack.sv
// Parametrised program counter with relative branches and a hardware call/return stack.
// The PC reaches the address bus through the tri-state `transmitter` buffer.

module transmitter #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_data,
    input  logic         i_noe,
    output logic [W-1:0] o_data
);
    assign o_data = i_noe ? {W{1'bz}} : i_data;
endmodule

module pc_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_nreset,
    input  logic [ADDR_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_offset,
    input  logic              i_loadData,
    input  logic              i_branch,
    input  logic              i_incr,
    input  logic              i_call,
    input  logic              i_ret,
    input  logic              i_clrErr,
    input  logic              i_noe,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [CNT_W-1:0]  o_depth,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_underflow
);

    if (ADDR_W < 2 || STACK_DEPTH < 1) begin : g_bad_params
        $error("pc_stack: ADDR_W must be >= 2 and STACK_DEPTH >= 1");
    end
    if (CNT_W != $clog2(STACK_DEPTH + 1)) begin : g_bad_cnt_w
        $error("pc_stack: CNT_W is derived from STACK_DEPTH and must not be overridden");
    end

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stack_top;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [CNT_W-1:0]  depth;
    logic [CNT_W-1:0]  depth_next;
    logic              empty;
    logic              full;
    logic              push;
    logic              ovf_set;
    logic              unf_set;
    logic              overflow;
    logic              underflow;

    assign pc_inc = pc + ADDR_W'(1);
    assign empty  = (depth == '0);
    assign full   = (depth == CNT_W'(STACK_DEPTH));

    // Entry depth-1 is the top; compare-and-select keeps the index within array bounds.
    always_comb begin
        stack_top = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (depth == CNT_W'(i + 1)) begin
                stack_top = stack_mem[i];
            end
        end
    end

    always_comb begin
        pc_next    = pc;
        depth_next = depth;
        push       = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        if (i_ret) begin
            if (empty) begin
                unf_set = 1'b1;
            end else begin
                pc_next    = stack_top;
                depth_next = depth - CNT_W'(1);
            end
        end else if (i_call) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                push       = 1'b1;
                pc_next    = i_data;
                depth_next = depth + CNT_W'(1);
            end
        end else if (i_loadData) begin
            pc_next = i_data;
        end else if (i_branch) begin
            pc_next = pc + i_offset;
        end else if (i_incr) begin
            pc_next = pc_inc;
        end
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            pc        <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc        <= pc_next;
            depth     <= depth_next;
            overflow  <= ovf_set | (overflow & ~i_clrErr);
            underflow <= unf_set | (underflow & ~i_clrErr);
        end
    end

    // Contents are don't-care after reset; only depth says what is valid.
    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (push && i_nreset && depth == CNT_W'(i)) begin
                stack_mem[i] <= pc_inc;
            end
        end
    end

    assign o_pc        = pc;
    assign o_depth     = depth;
    assign o_empty     = empty;
    assign o_full      = full;
    assign o_overflow  = overflow;
    assign o_underflow = underflow;

    transmitter #(.W(ADDR_W)) u_transmitter (
        .i_data (pc),
        .i_noe  (i_noe),
        .o_data (o_addr)
    );

endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack (ADDR_W=8, STACK_DEPTH=4).

module tb_pc_stack;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int CNT_W       = $clog2(STACK_DEPTH + 1);

    logic              i_clk = 1'b0;
    logic              i_nreset;
    logic [ADDR_W-1:0] i_data;
    logic [ADDR_W-1:0] i_offset;
    logic              i_loadData;
    logic              i_branch;
    logic              i_incr;
    logic              i_call;
    logic              i_ret;
    logic              i_clrErr;
    logic              i_noe;
    wire  [ADDR_W-1:0] o_addr;
    logic [ADDR_W-1:0] o_pc;
    logic [CNT_W-1:0]  o_depth;
    logic              o_empty;
    logic              o_full;
    logic              o_overflow;
    logic              o_underflow;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    pc_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .i_clk       (i_clk),
        .i_nreset    (i_nreset),
        .i_data      (i_data),
        .i_offset    (i_offset),
        .i_loadData  (i_loadData),
        .i_branch    (i_branch),
        .i_incr      (i_incr),
        .i_call      (i_call),
        .i_ret       (i_ret),
        .i_clrErr    (i_clrErr),
        .i_noe       (i_noe),
        .o_addr      (o_addr),
        .o_pc        (o_pc),
        .o_depth     (o_depth),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_cmds();
        i_loadData = 1'b0;
        i_branch   = 1'b0;
        i_incr     = 1'b0;
        i_call     = 1'b0;
        i_ret      = 1'b0;
        i_clrErr   = 1'b0;
    endtask

    // Apply the commands currently set for one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge i_clk);
        #1;
        clear_cmds();
    endtask

    task automatic do_call(input logic [ADDR_W-1:0] tgt);
        i_call = 1'b1;
        i_data = tgt;
        step();
    endtask

    task automatic do_ret();
        i_ret = 1'b1;
        step();
    endtask

    task automatic check_state(input string tag, input logic [ADDR_W-1:0] pc, input int unsigned depth);
        check({tag, "_pc"}, 32'(o_pc), 32'(pc));
        check({tag, "_depth"}, 32'(o_depth), 32'(depth));
    endtask

    initial begin
        i_nreset = 1'b0;
        i_data   = '0;
        i_offset = '0;
        i_noe    = 1'b0;
        clear_cmds();
        #3;
        check("rst_pc", 32'(o_pc), 32'h0);
        check("rst_depth", 32'(o_depth), 32'h0);
        check("rst_empty", 32'(o_empty), 32'h1);
        check("rst_full", 32'(o_full), 32'h0);
        check("rst_ovf", 32'(o_overflow), 32'h0);
        check("rst_unf", 32'(o_underflow), 32'h0);
        #4 i_nreset = 1'b1;

        // Increment, then asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            i_incr = 1'b1;
            step();
        end
        check("incr3", 32'(o_pc), 32'h03);
        check("addr_incr3", 32'(o_addr), 32'h03);
        #2 i_nreset = 1'b0;
        #1;
        check("async_rst_pc", 32'(o_pc), 32'h0);
        check("async_rst_empty", 32'(o_empty), 32'h1);
        i_nreset = 1'b1;

        // Wrap and load/branch
        i_loadData = 1'b1; i_data = 8'hFF; step();
        check("load_ff", 32'(o_pc), 32'hFF);
        i_incr = 1'b1; step();
        check("incr_wrap", 32'(o_pc), 32'h00);
        i_loadData = 1'b1; i_data = 8'h40; step();
        check("load_40", 32'(o_pc), 32'h40);
        i_branch = 1'b1; i_offset = 8'h10; step();
        check("branch_fwd", 32'(o_pc), 32'h50);
        i_branch = 1'b1; i_offset = 8'hF0; step();
        check("branch_back", 32'(o_pc), 32'h40);
        i_loadData = 1'b1; i_branch = 1'b1; i_incr = 1'b1; i_data = 8'h20; i_offset = 8'h05; step();
        check("load_wins", 32'(o_pc), 32'h20);
        step();
        check("idle_hold", 32'(o_pc), 32'h20);
        i_call = 1'b1; i_loadData = 1'b1; i_data = 8'h10; step();
        check_state("call_over_load", 8'h10, 1);
        do_ret();
        check_state("ret_to_21", 8'h21, 0);

        // Nested call/return
        i_loadData = 1'b1; i_data = 8'h10; step();
        do_call(8'h80);
        check_state("call1", 8'h80, 1);
        do_call(8'hA0);
        check_state("call2", 8'hA0, 2);
        do_ret();
        check_state("ret1", 8'h81, 1);
        do_ret();
        check_state("ret2", 8'h11, 0);
        check("ret2_empty", 32'(o_empty), 32'h1);

        // Fill the stack and overflow it
        do_call(8'h20);
        do_call(8'h30);
        do_call(8'h40);
        do_call(8'h50);
        check_state("fill", 8'h50, 4);
        check("fill_full", 32'(o_full), 32'h1);
        check("fill_ovf0", 32'(o_overflow), 32'h0);
        do_call(8'hC0);
        check_state("ovf_call", 8'h50, 4);
        check("ovf_set", 32'(o_overflow), 32'h1);
        do_ret();
        check_state("unwind1", 8'h41, 3);
        do_ret();
        check_state("unwind2", 8'h31, 2);
        do_ret();
        check_state("unwind3", 8'h21, 1);
        do_ret();
        check_state("unwind4", 8'h12, 0);
        check("ovf_sticky", 32'(o_overflow), 32'h1);
        i_clrErr = 1'b1; step();
        check("ovf_clr", 32'(o_overflow), 32'h0);

        // Underflow, clear/set race, clear alongside a command
        do_ret();
        check_state("unf_ret", 8'h12, 0);
        check("unf_set", 32'(o_underflow), 32'h1);
        i_clrErr = 1'b1; i_ret = 1'b1; step();
        check("unf_race", 32'(o_underflow), 32'h1);
        i_clrErr = 1'b1; i_incr = 1'b1; step();
        check("unf_clr", 32'(o_underflow), 32'h0);
        check("clr_with_incr", 32'(o_pc), 32'h13);

        // Bus enable
        i_noe = 1'b1;
        #1;
        check("noe_pc", 32'(o_pc), 32'h13);
        check("noe_addr_released", 32'(o_addr === 8'h13), 32'h0);
        i_noe = 1'b0;
        #1;
        check("oe_addr", 32'(o_addr), 32'h13);

        // Reset during a pending call at depth 2
        do_ret();
        do_call(8'h60);
        do_call(8'h70);
        check_state("pre_rst", 8'h70, 2);
        check("pre_rst_unf", 32'(o_underflow), 32'h1);
        i_call = 1'b1; i_data = 8'h90;
        #2 i_nreset = 1'b0;
        #1;
        check_state("mid_rst", 8'h00, 0);
        check("mid_rst_unf", 32'(o_underflow), 32'h0);
        check("mid_rst_ovf", 32'(o_overflow), 32'h0);
        @(posedge i_clk);
        #1;
        check_state("rst_held_edge", 8'h00, 0);
        i_nreset = 1'b1;
        clear_cmds();
        step();
        check_state("post_rst_idle", 8'h00, 0);
        do_ret();
        check("post_rst_no_push", 32'(o_underflow), 32'h1);
        check_state("post_rst_ret", 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
